// File: rtl/final_result_pkg.sv
// Shared definitions for the final-result arbitration slice.
// Optional feature macro: SEQ_CHECK_EN (tag-order checking, drives SEQ_ERR).
package final_result_pkg;
  localparam int OUT_W = 4;
  localparam int SEQ_W = 64;

  typedef logic [SEQ_W-1:0] seq_t;
  typedef logic [OUT_W-1:0] out_t;

  // Bit positions inside OUT / COMBO_OUT / SEQ_OUT
  localparam int OUT_CHSYNC_CLK = 0;
  localparam int OUT_DATA       = 1;
  localparam int OUT_HITOR      = 2;
  localparam int OUT_LOCKED     = 3;
endpackage

// File: rtl/final_path_reg.sv
// One result path: captures tag + value on a write enable and exposes the
// post-edge (next) contents so the top can register its selection with
// latency 1. Under SEQ_CHECK_EN it also flags a non-increasing tag.
module final_path_reg
  import final_result_pkg::*;
#(
  parameter int P_OUT_W = OUT_W,
  parameter int P_SEQ_W = SEQ_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               i_we,
  input  logic [P_SEQ_W-1:0] i_tag,
  input  logic [P_OUT_W-1:0] i_val,
  output logic [P_SEQ_W-1:0] o_tag_nxt,
  output logic [P_OUT_W-1:0] o_val_nxt
`ifdef SEQ_CHECK_EN
  ,
  output logic               o_order_err
`endif
);
  logic [P_SEQ_W-1:0] r_tag;
  logic [P_OUT_W-1:0] r_val;

  // Contents as they will be after this edge (reset handled by the consumer)
  always_comb begin
    o_tag_nxt = i_we ? i_tag : r_tag;
    o_val_nxt = i_we ? i_val : r_val;
  end

  // Tag/value storage; reset wins over a concurrent write
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tag <= '0;
      r_val <= '0;
    end else if (i_we) begin
      r_tag <= i_tag;
      r_val <= i_val;
    end
  end

`ifdef SEQ_CHECK_EN
  // A path's tags must strictly increase; the update is still stored
  assign o_order_err = i_we && (i_tag <= r_tag);
`endif
endmodule

// File: rtl/final_result_select.sv
// Output arbitration: drives OUT from whichever path holds the strictly
// newer tag (ties go to combo), with a sticky FINAL freeze.
// Optional feature macro: SEQ_CHECK_EN (sticky tag-order error on SEQ_ERR).
module final_result_select
  import final_result_pkg::*;
#(
  parameter int P_OUT_W = OUT_W,
  parameter int P_SEQ_W = SEQ_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               COMBO_VLD,
  input  logic [P_SEQ_W-1:0] COMBO_SEQ,
  input  logic [P_OUT_W-1:0] COMBO_OUT,
  input  logic               SEQ_VLD,
  input  logic [P_SEQ_W-1:0] SEQ_SEQ,
  input  logic [P_OUT_W-1:0] SEQ_OUT,
  input  logic               FINAL,
  output logic [P_OUT_W-1:0] OUT,
  output logic               SEL_SEQ,
  output logic               FINAL_DONE,
  output logic               SEQ_ERR
);
  logic               r_final_done;
  logic [P_OUT_W-1:0] r_out;
  logic               r_sel_seq;

  logic               w_open;
  logic               w_combo_we;
  logic               w_seq_we;
  logic [P_SEQ_W-1:0] w_combo_tag_nxt;
  logic [P_OUT_W-1:0] w_combo_val_nxt;
  logic [P_SEQ_W-1:0] w_seq_tag_nxt;
  logic [P_OUT_W-1:0] w_seq_val_nxt;
  logic               w_sel_nxt;

  // Strobes are accepted only while not frozen and not in the FINAL cycle
  always_comb begin
    w_open     = !r_final_done && !FINAL;
    w_combo_we = COMBO_VLD && w_open;
    w_seq_we   = SEQ_VLD && w_open;
  end

`ifdef SEQ_CHECK_EN
  logic w_combo_err;
  logic w_seq_err;
  logic r_seq_err;
`endif

  final_path_reg #(.P_OUT_W(P_OUT_W), .P_SEQ_W(P_SEQ_W)) u_combo (
    .CLK       (CLK),
    .RST       (RST),
    .i_we      (w_combo_we),
    .i_tag     (COMBO_SEQ),
    .i_val     (COMBO_OUT),
    .o_tag_nxt (w_combo_tag_nxt),
    .o_val_nxt (w_combo_val_nxt)
`ifdef SEQ_CHECK_EN
    ,
    .o_order_err (w_combo_err)
`endif
  );

  final_path_reg #(.P_OUT_W(P_OUT_W), .P_SEQ_W(P_SEQ_W)) u_seq (
    .CLK       (CLK),
    .RST       (RST),
    .i_we      (w_seq_we),
    .i_tag     (SEQ_SEQ),
    .i_val     (SEQ_OUT),
    .o_tag_nxt (w_seq_tag_nxt),
    .o_val_nxt (w_seq_val_nxt)
`ifdef SEQ_CHECK_EN
    ,
    .o_order_err (w_seq_err)
`endif
  );

  // Select on the just-captured tags so simultaneous strobes still see latency 1
  assign w_sel_nxt = w_seq_tag_nxt > w_combo_tag_nxt;

  // Registered output mux and sticky freeze; RST overrides the frozen state
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out        <= '0;
      r_sel_seq    <= 1'b0;
      r_final_done <= 1'b0;
    end else if (!r_final_done) begin
      r_out        <= w_sel_nxt ? w_seq_val_nxt : w_combo_val_nxt;
      r_sel_seq    <= w_sel_nxt;
      r_final_done <= FINAL;
    end
  end

`ifdef SEQ_CHECK_EN
  // Sticky tag-order error: per-path regressions or a same-cycle tag tie
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_seq_err <= 1'b0;
    end else if (w_combo_err || w_seq_err ||
                 (w_combo_we && w_seq_we && (COMBO_SEQ == SEQ_SEQ))) begin
      r_seq_err <= 1'b1;
    end
  end
  assign SEQ_ERR = r_seq_err;
`else
  assign SEQ_ERR = 1'b0;
`endif

  assign OUT        = r_out;
  assign SEL_SEQ    = r_sel_seq;
  assign FINAL_DONE = r_final_done;
endmodule

// File: tb/tb_final_result_select.sv
// Self-checking bench for final_result_select: directed scenarios with
// literal expectations plus a per-cycle compare against a behavioural model.
module tb_final_result_select;
  import final_result_pkg::*;

  logic CLK = 1'b0;
  logic RST, COMBO_VLD, SEQ_VLD, FINAL;
  seq_t COMBO_SEQ, SEQ_SEQ;
  out_t COMBO_OUT, SEQ_OUT;
  out_t OUT;
  logic SEL_SEQ, FINAL_DONE, SEQ_ERR;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  final_result_select dut (
    .CLK(CLK), .RST(RST),
    .COMBO_VLD(COMBO_VLD), .COMBO_SEQ(COMBO_SEQ), .COMBO_OUT(COMBO_OUT),
    .SEQ_VLD(SEQ_VLD), .SEQ_SEQ(SEQ_SEQ), .SEQ_OUT(SEQ_OUT),
    .FINAL(FINAL), .OUT(OUT), .SEL_SEQ(SEL_SEQ),
    .FINAL_DONE(FINAL_DONE), .SEQ_ERR(SEQ_ERR)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: last accepted update per path, newest tag wins
  seq_t m_ctag, m_stag;
  out_t m_cval, m_sval, m_out;
  logic m_sel, m_done, m_err;

  always @(posedge CLK) begin
    if (RST) begin
      m_ctag = '0; m_stag = '0; m_cval = '0; m_sval = '0;
      m_out = '0; m_sel = 1'b0; m_done = 1'b0; m_err = 1'b0;
    end else if (!m_done) begin
      if (FINAL) begin
        m_done = 1'b1;
      end else begin
        if (CHK && ((COMBO_VLD && COMBO_SEQ <= m_ctag) ||
                    (SEQ_VLD && SEQ_SEQ <= m_stag) ||
                    (COMBO_VLD && SEQ_VLD && COMBO_SEQ == SEQ_SEQ)))
          m_err = 1'b1;
        if (COMBO_VLD) begin m_ctag = COMBO_SEQ; m_cval = COMBO_OUT; end
        if (SEQ_VLD)   begin m_stag = SEQ_SEQ;   m_sval = SEQ_OUT;   end
      end
      m_sel = (m_stag > m_ctag);
      m_out = m_sel ? m_sval : m_cval;
    end
    #1;
    chk("model_out",  OUT,        m_out);
    chk("model_sel",  SEL_SEQ,    m_sel);
    chk("model_done", FINAL_DONE, m_done);
    chk("model_err",  SEQ_ERR,    m_err);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One input cycle, driven on the falling edge
  task automatic cyc(input logic rst, input logic cv, input seq_t cs, input out_t co,
                     input logic sv, input seq_t ss, input out_t so, input logic fin);
    @(negedge CLK);
    RST = rst; COMBO_VLD = cv; COMBO_SEQ = cs; COMBO_OUT = co;
    SEQ_VLD = sv; SEQ_SEQ = ss; SEQ_OUT = so; FINAL = fin;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    RST = 1'b1; COMBO_VLD = 1'b0; SEQ_VLD = 1'b0; FINAL = 1'b0;
    COMBO_SEQ = '0; SEQ_SEQ = '0; COMBO_OUT = '0; SEQ_OUT = '0;

    // 1. Reset for two cycles
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("rst_out", OUT, 4'h0);
    chk("rst_sel", SEL_SEQ, 1'b0);
    chk("rst_done", FINAL_DONE, 1'b0);
    chk("rst_err", SEQ_ERR, 1'b0);

    // 2. Combo then seq, each visible one cycle after its strobe
    cyc(0, 1, 64'd5, 4'hA, 0, 0, 0, 0);
    idle();
    chk("combo5_out", OUT, 4'hA);
    chk("combo5_sel", SEL_SEQ, 1'b0);
    cyc(0, 0, 0, 0, 1, 64'd6, 4'h3, 0);
    idle();
    chk("seq6_out", OUT, 4'h3);
    chk("seq6_sel", SEL_SEQ, 1'b1);

    // 3. Simultaneous strobes with equal tags: combo wins
    cyc(0, 1, 64'd9, 4'h1, 1, 64'd9, 4'hF, 0);
    idle();
    chk("tie_out", OUT, 4'h1);
    chk("tie_sel", SEL_SEQ, 1'b0);
    chk("tie_err", SEQ_ERR, CHK);

    // 4. FINAL freezes; a later strobe and a same-cycle strobe are ignored
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 64'd20, 4'h7, 0, 0, 0, 0);
    idle();
    chk("frz_done", FINAL_DONE, 1'b1);
    chk("frz_out", OUT, 4'h1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("unfrz_done", FINAL_DONE, 1'b0);
    chk("unfrz_out", OUT, 4'h0);
    cyc(0, 1, 64'd3, 4'h5, 0, 0, 0, 0);
    cyc(0, 1, 64'd50, 4'hE, 1, 64'd60, 4'h2, 1);
    idle();
    chk("fin_strobe_out", OUT, 4'h5);
    chk("fin_strobe_sel", SEL_SEQ, 1'b0);
    chk("fin_strobe_done", FINAL_DONE, 1'b1);

    // 5. Seq tag regression: 10 then 8, still newer than combo tag 0
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 64'd10, 4'h5, 0);
    cyc(0, 0, 0, 0, 1, 64'd8, 4'hC, 0);
    idle();
    chk("regr_out", OUT, 4'hC);
    chk("regr_sel", SEL_SEQ, 1'b1);
    chk("regr_err", SEQ_ERR, CHK);
    idle();
    chk("regr_err_sticky", SEQ_ERR, CHK);

    // 6. RST with a concurrent strobe discards the update
    cyc(1, 0, 0, 0, 1, 64'd3, 4'h9, 0);
    idle();
    chk("rstupd_out", OUT, 4'h0);
    chk("rstupd_sel", SEL_SEQ, 1'b0);
    chk("rstupd_err", SEQ_ERR, 1'b0);
    cyc(0, 1, 64'd2, 4'h4, 0, 0, 0, 0);
    idle();
    chk("rstupd_tag_out", OUT, 4'h4);
    chk("rstupd_tag_sel", SEL_SEQ, 1'b0);

    // Full-width unsigned compare on the top tag bit
    cyc(0, 0, 0, 0, 1, 64'h8000_0000_0000_0000, 4'h6, 0);
    cyc(0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 4'hB, 0, 0, 0, 0);
    idle();
    chk("msb_out", OUT, 4'h6);
    chk("msb_sel", SEL_SEQ, 1'b1);

    // Mixed traffic, checked by the model each cycle
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 60) == 0), $urandom_range(0, 1), seq_t'($urandom_range(0, 40)),
          out_t'($urandom), $urandom_range(0, 1), seq_t'($urandom_range(0, 40)),
          out_t'($urandom), ($urandom_range(0, 40) == 0));
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
